// File: rtl/ect_usb_pkg.sv
// Shared definitions for the ECT USB path: drain FSM states, the frame end
// marker used by both the FIFO writer and the drain, and the bulk packet size.
package ect_usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_LATCH  = 3'd2,
        ST_WR_HI  = 3'd3,
        ST_WR_LO  = 3'd4,
        ST_PKTEND = 3'd5
    } drain_state_e;

    // 16-bit writes per full 512-byte bulk packet
    localparam int unsigned USB_PKT_HALFWORDS = 256;

    // Frame end word; seeing it forces a short-packet commit
    localparam logic [31:0] USB_END_MARKER = 32'hFAFAE0E0;

endpackage

// File: rtl/usb_pkt_drain.sv
// usb_pkt_drain: pulls 32-bit words from the USB staging FIFO and writes them
// to the FX2 slave FIFO as two 16-bit halves (high half first). A frame end
// marker commits a short packet with PKTEND unless it landed exactly on a
// packet boundary, where the FX2 auto-commits. All outputs are registered.
module usb_pkt_drain
    import ect_usb_pkg::*;
#(
    parameter int unsigned PKT_HALFWORDS = USB_PKT_HALFWORDS,
    parameter logic [31:0] END_MARKER    = USB_END_MARKER
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        FifoEmpty,
    input  logic [31:0] FifoRdData,
    output logic        FifoRdReq,
    input  logic        FlagFullN,
    output logic [15:0] FD,
    output logic        SlwrN,
    output logic        PktendN,
    output logic        FrameDone,
    output logic        Busy
);

    localparam int unsigned CNT_W = (PKT_HALFWORDS > 2) ? $clog2(PKT_HALFWORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_HALFWORDS - 1);

    drain_state_e     state_q, state_d;
    logic             rd_req_q, rd_req_d;
    logic             slwr_n_q, slwr_n_d;
    logic             pktend_n_q, pktend_n_d;
    logic [15:0]      fd_q, fd_d;
    logic [31:0]      word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;

    // Next-state and registered-output decode. The strobe registers hold the
    // value that is on the pins in the current cycle, so a low slwr_n_q in a
    // write state means that half is being written right now; the full flag
    // sampled at the end of a cycle decides the strobe of the following cycle.
    always_comb begin
        state_d      = state_q;
        rd_req_d     = 1'b0;
        slwr_n_d     = 1'b1;
        pktend_n_d   = 1'b1;
        fd_d         = fd_q;
        word_d       = word_q;
        frame_done_d = 1'b0;

        cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        cnt_d   = slwr_n_q ? cnt_q : cnt_inc;

        unique case (state_q)
            ST_IDLE: begin
                if (!FifoEmpty) begin
                    state_d  = ST_RD;
                    rd_req_d = 1'b1;
                end
            end
            ST_RD: begin
                // Read data appears one cycle after the request
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                word_d  = FifoRdData;
                state_d = ST_WR_HI;
                if (FlagFullN) begin
                    slwr_n_d = 1'b0;
                    fd_d     = FifoRdData[31:16];
                end
            end
            ST_WR_HI: begin
                if (!slwr_n_q) begin
                    // High half is on the bus now; line up the low half
                    state_d = ST_WR_LO;
                    if (FlagFullN) begin
                        slwr_n_d = 1'b0;
                        fd_d     = word_q[15:0];
                    end
                end else if (FlagFullN) begin
                    slwr_n_d = 1'b0;
                    fd_d     = word_q[31:16];
                end
            end
            ST_WR_LO: begin
                if (!slwr_n_q) begin
                    if (word_q == END_MARKER) begin
                        if (cnt_inc != '0) begin
                            // Short packet: commit it explicitly
                            state_d    = ST_PKTEND;
                            pktend_n_d = ~FlagFullN;
                        end else begin
                            // Marker filled the packet; FX2 commits on its own
                            state_d      = ST_IDLE;
                            frame_done_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (FlagFullN) begin
                    slwr_n_d = 1'b0;
                    fd_d     = word_q[15:0];
                end
            end
            ST_PKTEND: begin
                if (!pktend_n_q) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                end else if (FlagFullN) begin
                    pktend_n_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any word in flight
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            rd_req_q     <= 1'b0;
            slwr_n_q     <= 1'b1;
            pktend_n_q   <= 1'b1;
            fd_q         <= 16'h0000;
            word_q       <= 32'h0000_0000;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_req_q     <= rd_req_d;
            slwr_n_q     <= slwr_n_d;
            pktend_n_q   <= pktend_n_d;
            fd_q         <= fd_d;
            word_q       <= word_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign FifoRdReq = rd_req_q;
    assign SlwrN     = slwr_n_q;
    assign PktendN   = pktend_n_q;
    assign FD        = fd_q;
    assign FrameDone = frame_done_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_usb_pkt_drain.sv
// Bench for usb_pkt_drain: a FIFO model feeds words, an event-level reference
// model predicts the FX2 write/commit sequence, plus exact-latency vectors.
module tb_usb_pkt_drain;

    localparam logic [31:0] END_W  = 32'hFAFAE0E0;
    localparam int          PKT_HW = 256;
    localparam int          FDEPTH = 2048;
    localparam logic [1:0]  EV_WR  = 2'd1;
    localparam logic [1:0]  EV_PE  = 2'd2;
    localparam logic [1:0]  EV_FD  = 2'd3;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        FifoEmpty = 1'b1;
    logic [31:0] FifoRdData = 32'h0;
    logic        FifoRdReq;
    logic        FlagFullN = 1'b1;
    logic [15:0] FD;
    logic        SlwrN;
    logic        PktendN;
    logic        FrameDone;
    logic        Busy;

    usb_pkt_drain dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .FifoEmpty  (FifoEmpty),
        .FifoRdData (FifoRdData),
        .FifoRdReq  (FifoRdReq),
        .FlagFullN  (FlagFullN),
        .FD         (FD),
        .SlwrN      (SlwrN),
        .PktendN    (PktendN),
        .FrameDone  (FrameDone),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    // Staging FIFO model (normal mode: data valid the cycle after the request)
    logic [31:0] fifo_mem [FDEPTH];
    int          fifo_wr = 0;
    int          fifo_rd = 0;

    always @(posedge Clk) begin
        if (FifoRdReq && (fifo_rd != fifo_wr)) begin
            FifoRdData <= fifo_mem[fifo_rd % FDEPTH];
            fifo_rd    <= fifo_rd + 1;
            FifoEmpty  <= ((fifo_rd + 1) == fifo_wr);
        end else begin
            FifoEmpty  <= (fifo_rd == fifo_wr);
        end
    end

    typedef struct packed {
        logic [31:0] word;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        pe;
        logic        fd;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_rd  = -100;
    int          last_wr_cyc = 0;
    int          last_pe_cyc = 0;
    int          last_fdone_cyc = 0;
    int          n_rd = 0, n_wr = 0, n_pe = 0, n_fdone = 0;
    int          m_cnt = 0;
    logic [15:0] last_fd = 16'h0;
    logic [17:0] exp_ev [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each word is two halfword writes, then a commit and/or
    // frame-done if it is the end marker, with the packet fill tracked modulo size
    task automatic push_word(input logic [31:0] w);
        fifo_mem[fifo_wr % FDEPTH] = w;
        fifo_wr++;
        exp_ev.push_back({EV_WR, w[31:16]});
        exp_ev.push_back({EV_WR, w[15:0]});
        m_cnt = (m_cnt + 2) % PKT_HW;
        if (w == END_W) begin
            if (m_cnt != 0) begin
                exp_ev.push_back({EV_PE, 16'h0});
                m_cnt = 0;
            end
            exp_ev.push_back({EV_FD, 16'h0});
        end
    endtask

    task automatic mon_event(input logic [17:0] ev);
        if (exp_ev.size() == 0) check("unexpected_event", 32'(ev), 32'h0);
        else check("event_order", 32'(ev), 32'(exp_ev.pop_front()));
    endtask

    task automatic mon();
        if (Rst == 1'b0) begin
            last_fd = 16'h0;
            last_rd = -100;
            return;
        end
        check("strobe_exclusive", 32'(SlwrN | PktendN), 32'd1);
        if (FifoRdReq) begin
            n_rd++;
            if (last_rd >= 0) check("rdreq_gap_gt4", 32'((cyc - last_rd) > 4), 32'd1);
            last_rd = cyc;
        end
        if (!SlwrN || !PktendN) check("strobe_while_full", 32'(FlagFullN), 32'd1);
        if (!SlwrN) begin
            n_wr++;
            last_wr_cyc = cyc;
            last_fd = FD;
            mon_event({EV_WR, FD});
        end else begin
            check("fd_hold", 32'(FD), 32'(last_fd));
        end
        if (!PktendN) begin
            n_pe++;
            last_pe_cyc = cyc;
            mon_event({EV_PE, 16'h0});
        end
        if (FrameDone) begin
            n_fdone++;
            last_fdone_cyc = cyc;
            mon_event({EV_FD, 16'h0});
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        cyc++;
        mon();
    endtask

    task automatic wait_rdreq(input string name);
        int n = 0;
        while (!FifoRdReq && n < 50) begin
            tick();
            n++;
        end
        check({name, "_rdreq_seen"}, 32'(FifoRdReq), 32'd1);
    endtask

    function automatic bit is_idle();
        return (exp_ev.size() == 0) && (fifo_rd == fifo_wr) && !Busy;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!is_idle() && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(is_idle()), 32'd1);
    endtask

    task automatic clear_counts();
        n_rd = 0; n_wr = 0; n_pe = 0; n_fdone = 0;
    endtask

    initial begin
        logic [31:0] w;

        vecs[0] = '{32'h12345678, 16'h1234, 16'h5678, 1'b0, 1'b0};
        vecs[1] = '{32'hFAFAE0E0, 16'hFAFA, 16'hE0E0, 1'b1, 1'b1};
        vecs[2] = '{32'hFFFF0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{32'h00000000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{32'hFAFAE0E1, 16'hFAFA, 16'hE0E1, 1'b0, 1'b0};
        vecs[5] = '{32'hE0E0FAFA, 16'hE0E0, 16'hFAFA, 1'b0, 1'b0};
        vecs[6] = '{32'hFAFAE0E0, 16'hFAFA, 16'hE0E0, 1'b1, 1'b1};

        // Reset state
        FlagFullN = 1'b1;
        repeat (3) tick();
        check("rst_rdreq",  32'(FifoRdReq), 32'd0);
        check("rst_slwr",   32'(SlwrN),     32'd1);
        check("rst_pktend", 32'(PktendN),   32'd1);
        check("rst_fd",     32'(FD),        32'h0);
        check("rst_fdone",  32'(FrameDone), 32'd0);
        check("rst_busy",   32'(Busy),      32'd0);
        check("rst_cnt",    32'(dut.cnt_q), 32'd0);
        Rst = 1'b1;
        repeat (2) tick();

        // Exact-latency vectors, cycle 1 = FifoRdReq
        for (int i = 0; i < NVEC; i++) begin
            push_word(vecs[i].word);
            wait_rdreq($sformatf("vec%0d", i));
            tick();
            check($sformatf("vec%0d_c2_slwr", i), 32'(SlwrN), 32'd1);
            tick();
            check($sformatf("vec%0d_c3_slwr", i), 32'(SlwrN), 32'd0);
            check($sformatf("vec%0d_c3_fd", i),   32'(FD),    32'(vecs[i].hi));
            check($sformatf("vec%0d_c3_busy", i), 32'(Busy),  32'd1);
            tick();
            check($sformatf("vec%0d_c4_slwr", i), 32'(SlwrN), 32'd0);
            check($sformatf("vec%0d_c4_fd", i),   32'(FD),    32'(vecs[i].lo));
            tick();
            check($sformatf("vec%0d_c5_pktend", i), 32'(PktendN),   32'(!vecs[i].pe));
            check($sformatf("vec%0d_c5_fdone", i),  32'(FrameDone), 32'(vecs[i].fd && !vecs[i].pe));
            check($sformatf("vec%0d_c5_busy", i),   32'(Busy),      32'(vecs[i].pe));
            if (vecs[i].pe) begin
                tick();
                check($sformatf("vec%0d_c6_fdone", i),  32'(FrameDone), 32'd1);
                check($sformatf("vec%0d_c6_pktend", i), 32'(PktendN),   32'd1);
                check($sformatf("vec%0d_c6_busy", i),   32'(Busy),      32'd0);
            end
        end
        wait_idle("vectors", 20);

        // Three data words then the marker: short packet commit
        clear_counts();
        push_word(32'h01020304);
        push_word(32'h05060708);
        push_word(32'h090A0B0C);
        push_word(END_W);
        wait_idle("short_pkt", 100);
        check("short_pkt_strobes", 32'(n_wr),    32'd8);
        check("short_pkt_pktend",  32'(n_pe),    32'd1);
        check("short_pkt_fdone",   32'(n_fdone), 32'd1);
        check("short_pkt_pe_after_lo",   32'(last_pe_cyc - last_wr_cyc),    32'd1);
        check("short_pkt_fd_after_pe",   32'(last_fdone_cyc - last_pe_cyc), 32'd1);
        check("short_pkt_cnt",     32'(dut.cnt_q), 32'd0);

        // 127 data words then the marker: exactly one full packet, no PKTEND
        clear_counts();
        for (int i = 0; i < 127; i++) push_word(32'h10000000 + 32'(i));
        push_word(END_W);
        wait_idle("full_pkt", 1000);
        check("full_pkt_strobes", 32'(n_wr),    32'd256);
        check("full_pkt_pktend",  32'(n_pe),    32'd0);
        check("full_pkt_fdone",   32'(n_fdone), 32'd1);
        check("full_pkt_fd_after_lo", 32'(last_fdone_cyc - last_wr_cyc), 32'd1);
        check("full_pkt_cnt",     32'(dut.cnt_q), 32'd0);

        // Endpoint full between the two halves
        push_word(32'hAAAA5555);
        wait_rdreq("stall");
        tick();
        tick();
        check("stall_hi_slwr", 32'(SlwrN), 32'd0);
        check("stall_hi_fd",   32'(FD),    32'h0000AAAA);
        FlagFullN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("stall_wait%0d_slwr", i), 32'(SlwrN), 32'd1);
            check($sformatf("stall_wait%0d_fd", i),   32'(FD),    32'h0000AAAA);
        end
        FlagFullN = 1'b1;
        tick();
        check("stall_lo_slwr", 32'(SlwrN), 32'd0);
        check("stall_lo_fd",   32'(FD),    32'h00005555);
        wait_idle("stall", 20);

        // Reset while the low half is pending
        push_word(32'h11112222);
        wait_rdreq("midrst");
        tick();
        tick();
        check("midrst_hi_fd", 32'(FD), 32'h00001111);
        FlagFullN = 1'b0;
        tick();
        Rst = 1'b0;
        #1;
        check("midrst_rdreq",  32'(FifoRdReq), 32'd0);
        check("midrst_slwr",   32'(SlwrN),     32'd1);
        check("midrst_pktend", 32'(PktendN),   32'd1);
        check("midrst_fd",     32'(FD),        32'h0);
        check("midrst_fdone",  32'(FrameDone), 32'd0);
        check("midrst_busy",   32'(Busy),      32'd0);
        check("midrst_cnt",    32'(dut.cnt_q), 32'd0);
        tick();
        tick();
        exp_ev.delete();
        m_cnt = 0;
        Rst = 1'b1;
        FlagFullN = 1'b1;
        tick();
        check("postrst_idle_busy", 32'(Busy), 32'd0);
        push_word(32'h33334444);
        wait_rdreq("postrst");
        tick();
        tick();
        check("postrst_hi_fd",   32'(FD),    32'h00003333);
        check("postrst_hi_slwr", 32'(SlwrN), 32'd0);
        wait_idle("postrst", 20);
        check("postrst_cnt", 32'(dut.cnt_q), 32'd2);

        // Continuous non-empty FIFO
        clear_counts();
        for (int i = 0; i < 300; i++) begin
            w = $urandom();
            if (w == END_W) w = w ^ 32'h1;
            push_word(w);
        end
        wait_idle("stream", 2000);
        check("stream_rdreq",   32'(n_rd), 32'd300);
        check("stream_strobes", 32'(n_wr), 32'd600);

        // Random words and markers with a randomly stalling endpoint
        clear_counts();
        for (int i = 0; i < 200; i++) begin
            w = ($urandom_range(0, 7) == 0) ? END_W : $urandom();
            push_word(w);
        end
        begin
            int n = 0;
            while (!is_idle() && n < 6000) begin
                tick();
                FlagFullN = ($urandom_range(0, 3) != 0);
                n++;
            end
            FlagFullN = 1'b1;
            repeat (4) tick();
            check("random_drained", 32'(is_idle()), 32'd1);
        end
        check("random_rdreq", 32'(n_rd), 32'd200);
        check("random_strobes", 32'(n_wr), 32'd400);
        check("events_all_seen", 32'(exp_ev.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_pkt_drain.md
USB_PKT_DRAIN -- requirements
Module: usb_pkt_drain

Interface
REQ-001 Parameter PKT_HALFWORDS, default 256: 16-bit writes per full USB bulk packet (512 bytes).
REQ-002 Parameter END_MARKER, default 32'hFAFAE0E0: frame end word that triggers a short-packet commit.
REQ-003 Clk  input  1  system clock; all logic on its rising edge.
REQ-004 Rst  input  1  reset: asynchronous, active-low.
REQ-005 FifoEmpty  input  1  USB staging FIFO empty flag.
REQ-006 FifoRdData  input  32  FIFO read data; valid one cycle after FifoRdReq (normal, non-show-ahead mode).
REQ-007 FifoRdReq  output  1  FIFO read request; one-cycle pulse per word.
REQ-008 FlagFullN  input  1  FX2 endpoint full flag, active-low (0 = full).
REQ-009 FD  output  16  FX2 slave-FIFO data bus.
REQ-010 SlwrN  output  1  FX2 write strobe, active-low.
REQ-011 PktendN  output  1  FX2 packet-end strobe, active-low.
REQ-012 FrameDone  output  1  one-cycle pulse after END_MARKER is fully written (and committed, if committed).
REQ-013 Busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, RD, LATCH, WR_HI, WR_LO and PKTEND.
REQ-015 IDLE SHALL go to RD when FifoEmpty=0; otherwise it stays in IDLE.
REQ-016 RD SHALL drive FifoRdReq=1 for exactly one cycle, then go to LATCH.
REQ-017 LATCH SHALL register FifoRdData into a 32-bit word register, then go to WR_HI.
REQ-018 WR_HI with FlagFullN=1 SHALL drive FD=word[31:16] and SlwrN=0 for one cycle, then go to WR_LO.
REQ-019 WR_HI with FlagFullN=0 SHALL hold SlwrN=1 and the state, waiting without limit.
REQ-020 WR_LO SHALL write word[15:0] under the same full-flag rule, then:
  - go to PKTEND if word==END_MARKER and the halfword count after the write is not 0;
  - otherwise go to IDLE.
REQ-021 PKTEND with FlagFullN=1 SHALL drive PktendN=0 for one cycle, reset the halfword count to 0, pulse FrameDone, then go to IDLE.
REQ-022 PKTEND with FlagFullN=0 SHALL wait.
REQ-023 If END_MARKER lands exactly on a packet boundary (count wraps to 0), the block SHALL NOT assert PktendN; FrameDone SHALL pulse in the cycle after the WR_LO strobe.
REQ-024 The halfword counter SHALL:
  - be ceil(log2(PKT_HALFWORDS)) bits wide;
  - increment on each SlwrN=0 cycle;
  - wrap from PKT_HALFWORDS-1 to 0.
REQ-025 FD SHALL hold its last value when not strobing; SlwrN and PktendN SHALL never be low in the same cycle.
REQ-026 All outputs SHALL be registered; minimum word latency with FlagFullN=1 is:
  - RD at cycle 1;
  - HI strobe at cycle 3;
  - LO strobe at cycle 4;
  - PKTEND at cycle 5.
REQ-027 A new FIFO read SHALL NOT start until the current word, and its PKTEND if any, is complete.

Reset
REQ-028 While Rst=0, the block SHALL hold:
  - state IDLE;
  - FifoRdReq=0, SlwrN=1, PktendN=1;
  - FD=16'h0000, word register=0, halfword count=0;
  - FrameDone=0, Busy=0.
REQ-029 Reset asserted mid-word SHALL abandon the word; after release the block SHALL resume from IDLE with count 0 and no partial strobe.

Structure
REQ-030 The state encoding, END_MARKER and the default PKT_HALFWORDS SHALL live in shared package ect_usb_pkg, so the FIFO writer and this drain use one marker constant.
REQ-031 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-032 Single word 32'h12345678, FIFO otherwise empty, FlagFullN=1 -> FD=16'h1234 with SlwrN=0 at cycle 3, FD=16'h5678 at cycle 4, no PktendN, Busy=0 at cycle 5.
REQ-033 Three data words then END_MARKER -> 8 SlwrN pulses, then one PktendN pulse, then one FrameDone pulse; count returns to 0.
REQ-034 127 data words then END_MARKER (256 halfwords) -> no PktendN, FrameDone pulses, count=0.
REQ-035 FlagFullN=0 held for 10 cycles between the HI and LO halves of 32'hAAAA5555 -> SlwrN stays 1 and FD=16'hAAAA is held; FD=16'h5555 with SlwrN=0 on the first cycle FlagFullN=1.
REQ-036 Rst pulsed low during WR_LO -> all outputs at reset values; the next word starts at count 0 with its HI half first.
REQ-037 Continuous non-empty FIFO of 300 words -> exactly 300 FifoRdReq pulses and 600 strobes, never two FifoRdReq within 4 cycles.
